// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order branch tracker that drives the history cache write port and flags mispredicts
// Ports: clk, rst (async active-low); push_valid/push_pc/push_pred/push_ready from fetch;
// resolve_valid/resolve_taken/flush from execute; upd_we/upd_pc/upd_taken/mispredict to the cache
// and pipeline; count occupancy; underflow sticky error.
// Define BUQ_STATS_EN to add saturating stat_resolved/stat_mispred counters.
module branch_update_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [PC_WIDTH-1:0]      push_pc,
  input  logic                     push_pred,
  output logic                     push_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     upd_we,
  output logic [PC_WIDTH-1:0]      upd_pc,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow
`ifdef BUQ_STATS_EN
  ,
  output logic [15:0]              stat_resolved,
  output logic [15:0]              stat_mispred
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [PC_WIDTH-1:0] pc_mem [DEPTH];
  logic                pred_mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                push_acc, res_acc, miss;
  assign push_ready = (count != FULL) || resolve_valid;
  assign push_acc   = push_valid && push_ready && !flush;
  assign res_acc    = resolve_valid && (count != '0);
  assign miss       = res_acc && (pred_mem[rd_ptr] != resolve_taken);
  // when full with a same-cycle resolve, wr_ptr == rd_ptr: the head is read before this write lands
  always_ff @(posedge clk) begin
    if (push_acc) begin
      pc_mem[wr_ptr]   <= push_pc;
      pred_mem[wr_ptr] <= push_pred;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      upd_we     <= 1'b0;
      upd_pc     <= '0;
      upd_taken  <= 1'b0;
      mispredict <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      upd_we     <= res_acc;
      mispredict <= miss;
      if (res_acc) begin
        upd_pc    <= pc_mem[rd_ptr];
        upd_taken <= resolve_taken;
      end
      if (resolve_valid && count == '0) underflow <= 1'b1;
      wr_ptr <= flush ? '0 : wr_ptr + AW'(push_acc);
      rd_ptr <= flush ? '0 : rd_ptr + AW'(res_acc);
      count  <= flush ? '0 : count + (AW+1)'(push_acc) - (AW+1)'(res_acc);
    end
  end
`ifdef BUQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (res_acc && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
      if (miss && stat_mispred != 16'hFFFF) stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif
endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- In-order tracker between fetch and execute that drives the write port of the branch history cache.
- Fetch pushes each predicted branch: PC plus predicted direction. Execute resolves branches oldest-first.
- On each resolution the block emits a one-cycle cache write (we, update_pc, branch_taken) and flags mispredicts so the pipeline can flush.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two, >= 2.
- PC_WIDTH, 10, width of program counter; matches the cache pc/update_pc width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- push_valid  in  1  fetch presents a branch this cycle.
- push_pc  in  PC_WIDTH  PC of the pushed branch.
- push_pred  in  1  predicted direction (1 = taken).
- push_ready  out  1  queue can accept a push; combinational, equals not full or resolve_valid.
- resolve_valid  in  1  execute resolves the oldest branch.
- resolve_taken  in  1  actual direction of the oldest branch.
- flush  in  1  squash all queued entries.
- upd_we  out  1  write strobe to history cache.
- upd_pc  out  PC_WIDTH  update_pc to history cache.
- upd_taken  out  1  branch_taken to history cache.
- mispredict  out  1  one-cycle pulse: resolved direction differed from prediction.
- count  out  $clog2(DEPTH)+1  current occupancy.
- underflow  out  1  sticky: resolve received while empty.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers and count go to 0.
  - upd_we, upd_pc, upd_taken, mispredict and underflow go to 0.
  - Entry storage is don't-care.
- Storage: circular buffer of DEPTH entries {pc, pred}. Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately.
- Push: accepted when push_valid && push_ready. The entry is written at the write pointer, which then increments.
- Resolve: accepted when resolve_valid && count != 0. On the next edge:
  - upd_we=1.
  - upd_pc = head pc.
  - upd_taken = resolve_taken.
  - mispredict = (head pred != resolve_taken).
  - Read pointer increments.
- Latency: resolve in cycle N gives upd_we/mispredict high for exactly cycle N+1. These outputs are registered.
- With no accepted resolve, upd_we and mispredict are 0 in the following cycle. upd_pc and upd_taken hold their last values.
- Resolve while empty: no update is issued, underflow is set to 1, and underflow stays set until reset.
- Full plus simultaneous push and resolve: both are accepted and count is unchanged. push_ready is 1 in this case.
- Empty plus simultaneous push and resolve: the resolve is an underflow. A same-cycle push is not bypassed to the resolve; the pushed entry is enqueued.
- Push and resolve on a non-full, non-empty queue: both are accepted and count is unchanged.
- Flush:
  - Any same-cycle resolve is processed first (update and mispredict issued normally).
  - All entries are then discarded: pointers and count go to 0.
  - A same-cycle push is dropped.
  - push_ready is unaffected by flush.
- Priority per edge: flush clear > push enqueue. Resolve is always evaluated against pre-edge state.
- count never exceeds DEPTH. A push with push_ready=0 is ignored.

Optional Feature:
- Macro: BUQ_STATS_EN.
- When defined:
  - Adds outputs stat_resolved[15:0] and stat_mispred[15:0].
  - Both reset to 0.
  - They increment on each accepted resolve and each mispredict respectively.
  - Both saturate at 16'hFFFF (no wrap).
- When undefined: the ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Reset mid-operation: push 3 entries, pull rst low between edges -> count=0, upd_we=0, underflow=0 immediately, with no clock edge required.
- Basic flow: push {pc=10'h013, pred=1}, then resolve_taken=1 -> next cycle upd_we=1, upd_pc=10'h013, upd_taken=1, mispredict=0; count back to 0.
- Mispredict: push {10'h2A5, pred=0}, resolve_taken=1 -> upd_taken=1, mispredict=1 for one cycle only.
- Full/wrap:
  - Push 4 entries 0x100–0x103 -> push_ready=0 only when resolve_valid=0, count=4.
  - Then push 0x104 with a simultaneous resolve -> upd_pc=0x100, count=4.
  - 4 further resolves -> upd_pc=0x101, 0x102, 0x103, 0x104 in order.
- Flush with resolve: queue {0x050 pred=1, 0x051 pred=0}, assert flush+resolve_taken=0+push 0x052 together -> upd_pc=0x050, mispredict=1, count=0, 0x052 not stored.
- Underflow: resolve_valid=1 on empty queue -> upd_we=0, underflow=1 and held; with BUQ_STATS_EN, stat_resolved unchanged.
